vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing for the poker display pipeline. It drives the `DrawX`/`DrawY` pixel coordinates consumed by the `graphics` block, the sync and blanking signals for the video output stage, and frame/line boundary strobes. The poker FSM uses those strobes to update displayed game state only between frames.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 @ 60 Hz VGA raster timing generator.
// A clock divider produces the pixel-rate enable; horizontal and vertical
// counters give the pixel coordinates. Sync and blanking are registered from
// the next counter values, so they line up with DrawX/DrawY on the same edge.
//
// Ports:
//   clk            system clock, the only clock
//   reset          synchronous active-high reset
//   pixel_en       one-cycle pixel-rate enable (decoded from the divider)
//   DrawX          horizontal count, 0..H_TOTAL-1
//   DrawY          vertical count, 0..V_TOTAL-1
//   hs             horizontal sync, active-low (registered)
//   vs             vertical sync, active-low (registered)
//   active_nblank  high while (DrawX, DrawY) is in the visible region (registered)
//   line_end       strobe on the last pixel of each line
//   frame_end      strobe on the last pixel of each frame
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       active_nblank,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned DIV_W   = 4;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             an_q, an_d;
  logic             pix_en_c;
  logic             line_end_c;

  // Enable is gated by reset so it stays low while reset is held, even with CLK_DIV = 1.
  assign pix_en_c   = ~reset & (div_q == DIV_LAST);
  assign line_end_c = pix_en_c & (hc_q == H_LAST);

  // Next-state for divider and raster counters, plus sync/blank from next counts.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pix_en_c) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
    end
    hs_d = ~((hc_d >= HS_START) && (hc_d < HS_END));
    vs_d = ~((vc_d >= VS_START) && (vc_d < VS_END));
    an_d = (hc_d < H_VIS) && (vc_d < V_VIS);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      an_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      an_q  <= an_d;
    end
  end

  assign pixel_en      = pix_en_c;
  assign DrawX         = hc_q;
  assign DrawY         = vc_q;
  assign hs            = hs_q;
  assign vs            = vs_q;
  assign active_nblank = an_q;
  assign line_end      = line_end_c;
  assign frame_end     = line_end_c & (vc_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Three instances share clk/reset:
//   d0: default timing (CLK_DIV 4, 800x525) for reset and full-line checks
//   d1: reduced raster (CLK_DIV 2, H 8/2/3/2 = 15, V 6/2/2/3 = 13) for frame,
//       wrap and mid-frame reset checks
//   d2: CLK_DIV 1 with default horizontal timing and the reduced vertical one
module tb_vga_timing_gen;

  logic clk;
  logic reset;

  logic       pe0, hs0, vs0, an0, le0, fe0;
  logic [9:0] x0, y0;
  logic       pe1, hs1, vs1, an1, le1, fe1;
  logic [9:0] x1, y1;
  logic       pe2, hs2, vs2, an2, le2, fe2;
  logic [9:0] x2, y2;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen d0 (
    .clk(clk), .reset(reset), .pixel_en(pe0), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .active_nblank(an0), .line_end(le0), .frame_end(fe0)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) d1 (
    .clk(clk), .reset(reset), .pixel_en(pe1), .DrawX(x1), .DrawY(y1),
    .hs(hs1), .vs(vs1), .active_nblank(an1), .line_end(le1), .frame_end(fe1)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) d2 (
    .clk(clk), .reset(reset), .pixel_en(pe2), .DrawX(x2), .DrawY(y2),
    .hs(hs2), .vs(vs2), .active_nblank(an2), .line_end(le2), .frame_end(fe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and land on the following falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two reset edges, then release; returns just after release, before the first run edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int first_pe;
    int bad;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pe0 !== 1'b0 || pe2 !== 1'b0 || x0 !== 10'd0 || y0 !== 10'd0 ||
          hs0 !== 1'b1 || vs0 !== 1'b1 || an0 !== 1'b1 || le0 !== 1'b0 ||
          fe0 !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_values: %0d bad cycles (x=%0d y=%0d hs=%b vs=%b an=%b pe0=%b pe2=%b), required 0",
               bad, x0, y0, hs0, vs0, an0, pe0, pe2);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (pe2 !== 1'b1) begin
      n_fail++;
      $display("FAIL clkdiv1_pe_release: pixel_en=%b, required 1", pe2);
    end
    first_pe = -1;
    for (int k = 0; k < 6; k++) begin
      if (pe0 === 1'b1 && first_pe < 0) first_pe = k;
      tick();
    end
    n_checks++;
    if (first_pe !== 3) begin
      n_fail++;
      $display("FAIL first_pixel_en: cycle=%0d, required 3", first_pe);
    end
  endtask

  task automatic test_hline();
    int hs_low, hs_first, an_fall, le_cnt, le_x, coord_bad, sync_bad;
    logic [9:0] ex;
    do_reset();
    hs_low = 0; hs_first = -1; an_fall = -1; le_cnt = 0; le_x = -1;
    coord_bad = 0; sync_bad = 0;
    for (int k = 0; k < 3200; k++) begin
      ex = 10'(k / 4);
      if (x0 !== ex || y0 !== 10'd0) coord_bad++;
      if (hs0 !== ~((k / 4) >= 656 && (k / 4) < 752)) sync_bad++;
      if (pe0 === 1'b1 && hs0 === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x0);
      end
      if (an0 === 1'b0 && an_fall < 0) an_fall = int'(x0);
      if (le0 === 1'b1) begin
        le_cnt++;
        le_x = int'(x0);
      end
      tick();
    end
    n_checks++;
    if (coord_bad !== 0) begin
      n_fail++;
      $display("FAIL hline_drawx: %0d bad samples, required 0", coord_bad);
    end
    n_checks++;
    if (sync_bad !== 0) begin
      n_fail++;
      $display("FAIL hline_hs_align: %0d bad samples, required 0", sync_bad);
    end
    n_checks++;
    if (hs_low !== 96 || hs_first !== 656) begin
      n_fail++;
      $display("FAIL hline_hs_width: low=%0d start=%0d, required 96 at 656", hs_low, hs_first);
    end
    n_checks++;
    if (an_fall !== 640) begin
      n_fail++;
      $display("FAIL hline_blank_start: x=%0d, required 640", an_fall);
    end
    n_checks++;
    if (le_cnt !== 1 || le_x !== 799) begin
      n_fail++;
      $display("FAIL hline_line_end: count=%0d x=%0d, required 1 at 799", le_cnt, le_x);
    end
    n_checks++;
    if (x0 !== 10'd0 || y0 !== 10'd1) begin
      n_fail++;
      $display("FAIL hline_next_line: x=%0d y=%0d, required 0,1", x0, y0);
    end
  endtask

  task automatic test_frame();
    int hc, vc, bad, fe_cnt, fe_k, vs_low;
    logic ex_le, ex_fe;
    do_reset();
    bad = 0; fe_cnt = 0; fe_k = -1; vs_low = 0;
    for (int k = 0; k < 390; k++) begin
      hc = (k / 2) % 15;
      vc = (k / 30) % 13;
      ex_le = (k % 2 == 1) && (hc == 14);
      ex_fe = ex_le && (vc == 12);
      if (x1 !== 10'(hc) || y1 !== 10'(vc) ||
          hs1 !== ~(hc >= 10 && hc < 13) ||
          vs1 !== ~(vc >= 8 && vc < 10) ||
          an1 !== (hc < 8 && vc < 6) ||
          le1 !== ex_le || fe1 !== ex_fe || pe1 !== (k % 2 == 1))
        bad++;
      if (vs1 === 1'b0) vs_low++;
      if (fe1 === 1'b1) begin
        fe_cnt++;
        fe_k = k;
        if (le1 !== 1'b1 || x1 !== 10'd14 || y1 !== 10'd12) bad++;
      end
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame_raster: %0d bad samples, required 0", bad);
    end
    n_checks++;
    if (vs_low !== 60) begin
      n_fail++;
      $display("FAIL frame_vs_lines: vs low for %0d cycles, required 60 (lines 8..9)", vs_low);
    end
    n_checks++;
    if (fe_cnt !== 1 || fe_k !== 389) begin
      n_fail++;
      $display("FAIL frame_end_timing: count=%0d cycle=%0d, required 1 at 389", fe_cnt, fe_k);
    end
    n_checks++;
    if (x1 !== 10'd0 || y1 !== 10'd0 || an1 !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wrap: x=%0d y=%0d an=%b, required 0,0,1", x1, y1, an1);
    end
  endtask

  task automatic test_wrap();
    int fe_cnt, le_cnt, max_x, max_y;
    do_reset();
    fe_cnt = 0; le_cnt = 0; max_x = 0; max_y = 0;
    for (int k = 0; k < 3 * 390; k++) begin
      if (fe1 === 1'b1) fe_cnt++;
      if (le1 === 1'b1) le_cnt++;
      if (int'(x1) > max_x) max_x = int'(x1);
      if (int'(y1) > max_y) max_y = int'(y1);
      tick();
    end
    n_checks++;
    if (fe_cnt !== 3 || le_cnt !== 39) begin
      n_fail++;
      $display("FAIL wrap_counts: frame_end=%0d line_end=%0d, required 3 and 39", fe_cnt, le_cnt);
    end
    n_checks++;
    if (max_x !== 14 || max_y !== 12) begin
      n_fail++;
      $display("FAIL wrap_bounds: max x=%0d y=%0d, required 14 and 12", max_x, max_y);
    end
  endtask

  task automatic test_midframe_reset();
    int bad;
    do_reset();
    // Sample 113: x=11 (inside hsync), y=3, divider at its last count.
    for (int k = 0; k < 113; k++) tick();
    n_checks++;
    if (x1 !== 10'd11 || y1 !== 10'd3 || hs1 !== 1'b0 || pe1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: x=%0d y=%0d hs=%b pe=%b, required 11,3,0,1", x1, y1, hs1, pe1);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (pe1 !== 1'b0 || le1 !== 1'b0 || fe1 !== 1'b0 || pe2 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_gate: pe1=%b le1=%b fe1=%b pe2=%b, required 0", pe1, le1, fe1, pe2);
    end
    tick();
    n_checks++;
    if (x1 !== 10'd0 || y1 !== 10'd0 || hs1 !== 1'b1 || vs1 !== 1'b1 || an1 !== 1'b1 ||
        x0 !== 10'd0 || y0 !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: x=%0d y=%0d hs=%b vs=%b an=%b, required 0,0,1,1,1",
               x1, y1, hs1, vs1, an1);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (le1 !== 1'b0 || fe1 !== 1'b0 || pe1 !== 1'b0 || pe2 !== 1'b0 ||
          le2 !== 1'b0 || x2 !== 10'd0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mid_hold: %0d bad cycles while reset held, required 0", bad);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_clkdiv1();
    int bad, fe_cnt, fe_k, hc, vc;
    do_reset();
    bad = 0; fe_cnt = 0; fe_k = -1;
    for (int k = 0; k < 10400; k++) begin
      hc = k % 800;
      vc = (k / 800) % 13;
      if (pe2 !== 1'b1 || x2 !== 10'(hc) || y2 !== 10'(vc) ||
          hs2 !== ~(hc >= 656 && hc < 752) ||
          vs2 !== ~(vc >= 8 && vc < 10) ||
          an2 !== (hc < 640 && vc < 6) ||
          le2 !== (hc == 799))
        bad++;
      if (fe2 === 1'b1) begin
        fe_cnt++;
        fe_k = k;
      end
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clkdiv1_raster: %0d bad samples, required 0", bad);
    end
    n_checks++;
    if (fe_cnt !== 1 || fe_k !== 10399) begin
      n_fail++;
      $display("FAIL clkdiv1_period: count=%0d cycle=%0d, required 1 at 10399", fe_cnt, fe_k);
    end
    n_checks++;
    if (x2 !== 10'd0 || y2 !== 10'd0) begin
      n_fail++;
      $display("FAIL clkdiv1_wrap: x=%0d y=%0d, required 0,0", x2, y2);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_hline();
    test_frame();
    test_wrap();
    test_midframe_reset();
    test_clkdiv1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
